// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared constants, state encoding and point type for the triangle rasterizer
package tri_pkg;

    localparam int W      = 10;
    localparam int MAX_X  = 639;
    localparam int MAX_Y  = 479;
    localparam int AREA_W = 2 * W + 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } point_t;

    function automatic int area_width(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/tri_area.sv
// rtl/tri_area.sv - combinational signed twice-area of three unsigned points
module tri_area #(
    parameter int W  = 10,
    parameter int AW = 2 * W + 3
) (
    input  logic [W-1:0]         ax,
    input  logic [W-1:0]         ay,
    input  logic [W-1:0]         bx,
    input  logic [W-1:0]         by,
    input  logic [W-1:0]         cx,
    input  logic [W-1:0]         cy,
    output logic signed [AW-1:0] area
);

    logic signed [AW-1:0] sax, say, sbx, sby, scx, scy;

    // Zero-extend into the signed domain before differencing so nothing wraps.
    assign sax = signed'(AW'(ax));
    assign say = signed'(AW'(ay));
    assign sbx = signed'(AW'(bx));
    assign sby = signed'(AW'(by));
    assign scx = signed'(AW'(cx));
    assign scy = signed'(AW'(cy));

    assign area = sax * (sby - scy) + sbx * (scy - say) + scx * (say - sby);

endmodule

// File: rtl/triangle_raster_scan.sv
// rtl/triangle_raster_scan.sv - sweeps a triangle's clipped bounding box and streams covered pixels
module triangle_raster_scan #(
    parameter int W     = tri_pkg::W,
    parameter int MAX_X = tri_pkg::MAX_X,
    parameter int MAX_Y = tri_pkg::MAX_Y
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [W-1:0]   p1x,
    input  logic [W-1:0]   p1y,
    input  logic [W-1:0]   p2x,
    input  logic [W-1:0]   p2y,
    input  logic [W-1:0]   p3x,
    input  logic [W-1:0]   p3y,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic [W-1:0]   pix_x,
    output logic [W-1:0]   pix_y,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   pix_count
);
    import tri_pkg::*;

    localparam int AW = area_width(W);
    localparam logic [W-1:0] LIM_X = W'(MAX_X);
    localparam logic [W-1:0] LIM_Y = W'(MAX_Y);

    state_t state;
    logic [W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [W-1:0] xmin, xmax, ymax, cx, cy;
    logic [W-1:0] bx_min, bx_max, by_min, by_max;
    logic         a_neg;
    logic signed [AW-1:0] area_a, e1, e2, e3;
    logic         covered, can_eval, last_cand;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        bx_min = min3(v1x, v2x, v3x);
        by_min = min3(v1y, v2y, v3y);
        bx_max = max3(v1x, v2x, v3x);
        by_max = max3(v1y, v2y, v3y);
        if (bx_max > LIM_X) bx_max = LIM_X;
        if (by_max > LIM_Y) by_max = LIM_Y;
    end

    tri_area #(.W(W), .AW(AW)) u_area (
        .ax(v1x), .ay(v1y), .bx(v2x), .by(v2y), .cx(v3x), .cy(v3y), .area(area_a)
    );
    tri_area #(.W(W), .AW(AW)) u_e1 (
        .ax(cx), .ay(cy), .bx(v2x), .by(v2y), .cx(v3x), .cy(v3y), .area(e1)
    );
    tri_area #(.W(W), .AW(AW)) u_e2 (
        .ax(v1x), .ay(v1y), .bx(cx), .by(cy), .cx(v3x), .cy(v3y), .area(e2)
    );
    tri_area #(.W(W), .AW(AW)) u_e3 (
        .ax(v1x), .ay(v1y), .bx(v2x), .by(v2y), .cx(cx), .cy(cy), .area(e3)
    );

    // Inclusive test: each edge term is zero or shares the winding sign of the triangle.
    always_comb begin
        if (a_neg)
            covered = (e1[AW-1] || e1 == '0) && (e2[AW-1] || e2 == '0) && (e3[AW-1] || e3 == '0);
        else
            covered = !e1[AW-1] && !e2[AW-1] && !e3[AW-1];
        can_eval  = !pix_valid || pix_ready;
        last_cand = (cx == xmax) && (cy == ymax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_count <= '0;
            v1x <= '0; v1y <= '0; v2x <= '0; v2y <= '0; v3x <= '0; v3y <= '0;
            xmin <= '0; xmax <= '0; ymax <= '0;
            cx <= '0; cy <= '0;
            a_neg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        v1x <= p1x; v1y <= p1y;
                        v2x <= p2x; v2y <= p2y;
                        v3x <= p3x; v3y <= p3y;
                        pix_count <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    xmin  <= bx_min;
                    xmax  <= bx_max;
                    ymax  <= by_max;
                    cx    <= bx_min;
                    cy    <= by_min;
                    a_neg <= area_a[AW-1];
                    if (area_a == '0 || bx_min > LIM_X || by_min > LIM_Y) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (pix_valid && pix_ready) pix_valid <= 1'b0;
                    if (can_eval) begin
                        if (covered) begin
                            pix_x     <= cx;
                            pix_y     <= cy;
                            pix_valid <= 1'b1;
                            pix_count <= pix_count + 1'b1;
                        end
                        if (last_cand) begin
                            state <= DRAIN;
                        end else if (cx == xmax) begin
                            cx <= xmin;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!pix_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (pix_ready) begin
                        pix_valid <= 1'b0;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_raster_scan.sv
// tb/tb_triangle_raster_scan.sv - scoreboard bench for the triangle rasterizer
module tb_triangle_raster_scan;

    localparam int W     = 11;
    localparam int MAX_X = 639;
    localparam int MAX_Y = 479;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [W-1:0]   p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic [W-1:0]   pix_x, pix_y;
    logic           busy, done;
    logic [2*W:0]   pix_count;

    triangle_raster_scan #(.W(W), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y),
        .busy(busy), .done(done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int r_n, r_count, r_dones, r_done_idx, r_valid_idx, r_first, r_last;

    function automatic longint area(longint ax, longint ay, longint bx, longint by,
                                    longint cx, longint cy);
        return ax * (by - cy) + bx * (cy - ay) + cx * (ay - by);
    endfunction

    function automatic int enc(int x, int y);
        return x * 4096 + y;
    endfunction

    task automatic build_expected(input int x1, y1, x2, y2, x3, y3);
        longint a, e1, e2, e3;
        int xmin, xmax, ymin, ymax;
        bit ok;
        exp_q.delete();
        a = area(x1, y1, x2, y2, x3, y3);
        if (a == 0) return;
        xmin = (x1 < x2) ? x1 : x2;  xmin = (x3 < xmin) ? x3 : xmin;
        ymin = (y1 < y2) ? y1 : y2;  ymin = (y3 < ymin) ? y3 : ymin;
        xmax = (x1 > x2) ? x1 : x2;  xmax = (x3 > xmax) ? x3 : xmax;
        ymax = (y1 > y2) ? y1 : y2;  ymax = (y3 > ymax) ? y3 : ymax;
        if (xmax > MAX_X) xmax = MAX_X;
        if (ymax > MAX_Y) ymax = MAX_Y;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                e1 = area(x, y, x2, y2, x3, y3);
                e2 = area(x1, y1, x, y, x3, y3);
                e3 = area(x1, y1, x2, y2, x, y);
                if (a > 0) ok = (e1 >= 0) && (e2 >= 0) && (e3 >= 0);
                else       ok = (e1 <= 0) && (e2 <= 0) && (e3 <= 0);
                if (ok) exp_q.push_back(enc(x, y));
            end
        end
    endtask

    // Drives one command and consumes the pixel stream; idx counts negedges after the accept edge.
    task automatic run_tri(input string tag, input int x1, y1, x2, y2, x3, y3,
                           input int stall, input bit poke);
        int  stall_left, hold, cur, e;
        bit  seen;
        build_expected(x1, y1, x2, y2, x3, y3);
        r_n = 0; r_count = -1; r_dones = 0; r_done_idx = -1; r_valid_idx = -1;
        r_first = -1; r_last = -1; seen = 1'b0; stall_left = 0; hold = 0;
        @(negedge clk);
        p1x = W'(x1); p1y = W'(y1); p2x = W'(x2); p2y = W'(y2); p3x = W'(x3); p3y = W'(y3);
        cmd_valid = 1'b1;
        pix_ready = 1'b1;
        for (int idx = 1; idx <= 3000; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                cmd_valid = 1'b0;
                n_vec++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_after_accept: busy=%b cmd_ready=%b, required 1/0", tag, busy, cmd_ready);
                end
            end
            if (poke && idx == 6) begin
                p1x = 11'd50; p1y = 11'd50; p2x = 11'd90; p2y = 11'd50; p3x = 11'd50; p3y = 11'd90;
                cmd_valid = 1'b1;
                n_vec++;
                if (cmd_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s cmd_ready_midscan: got %b, required 0", tag, cmd_ready);
                end
            end
            if (poke && idx == 7) cmd_valid = 1'b0;
            if (done === 1'b1) begin
                r_dones++;
                r_done_idx = idx;
                r_count = int'(pix_count);
            end
            if (pix_valid === 1'b1) begin
                cur = enc(int'(pix_x), int'(pix_y));
                if (!seen) begin
                    seen = 1'b1;
                    r_valid_idx = idx;
                    hold = cur;
                    stall_left = stall;
                end
                if (stall_left > 0) begin
                    n_vec++;
                    if (cur !== hold) begin
                        n_err++;
                        $display("FAIL %s hold_stable: got %0d,%0d required %0d,%0d",
                                 tag, cur / 4096, cur % 4096, hold / 4096, hold % 4096);
                    end
                    stall_left--;
                    pix_ready = 1'b0;
                end else begin
                    pix_ready = 1'b1;
                end
                if (pix_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s extra_pixel: got %0d,%0d required none", tag, cur / 4096, cur % 4096);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL %s pixel: got %0d,%0d required %0d,%0d",
                                     tag, cur / 4096, cur % 4096, e / 4096, e % 4096);
                        end
                    end
                    n_vec++;
                    if (int'(pix_x) > MAX_X || int'(pix_y) > MAX_Y) begin
                        n_err++;
                        $display("FAIL %s clip: got %0d,%0d required x<=%0d y<=%0d",
                                 tag, pix_x, pix_y, MAX_X, MAX_Y);
                    end
                    if (r_first < 0) r_first = cur;
                    r_last = cur;
                    r_n++;
                end
            end
            if (r_done_idx >= 0) break;
        end
        if (r_done_idx < 0) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no done within 3000 cycles, required done", tag);
        end
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) r_dones++;
        end
        n_vec++;
        if (exp_q.size() != 0 || pix_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s tail: missing=%0d pix_valid=%b cmd_ready=%b, required 0/0/1",
                     tag, exp_q.size(), pix_valid, cmd_ready);
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pix_x !== '0 || pix_y !== '0 || pix_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b pv=%b busy=%b done=%b x=%0d y=%0d cnt=%0d, required 1 0 0 0 0 0 0",
                     cmd_ready, pix_valid, busy, done, pix_x, pix_y, pix_count);
        end
    endtask

    task automatic test_winding(input string tag, input int x2, y2, x3, y3);
        run_tri(tag, 0, 0, x2, y2, x3, y3, 0, 1'b0);
        n_vec++;
        if (r_n !== 15 || r_count !== 15 || r_dones !== 1) begin
            n_err++;
            $display("FAIL %s totals: pixels=%0d count=%0d dones=%0d, required 15 15 1", tag, r_n, r_count, r_dones);
        end
        n_vec++;
        if (r_first !== enc(0, 0) || r_last !== enc(0, 4) || r_valid_idx !== 3) begin
            n_err++;
            $display("FAIL %s ends: first=%0d last=%0d valid_idx=%0d, required %0d %0d 3",
                     tag, r_first, r_last, r_valid_idx, enc(0, 0), enc(0, 4));
        end
    endtask

    task automatic test_degenerate(input string tag, input int x1, y1, x2, y2, x3, y3);
        run_tri(tag, x1, y1, x2, y2, x3, y3, 0, 1'b0);
        n_vec++;
        if (r_n !== 0 || r_valid_idx !== -1 || r_done_idx !== 2 || r_count !== 0 || r_dones !== 1) begin
            n_err++;
            $display("FAIL %s degenerate: pixels=%0d valid_idx=%0d done_idx=%0d count=%0d dones=%0d, required 0 -1 2 0 1",
                     tag, r_n, r_valid_idx, r_done_idx, r_count, r_dones);
        end
    endtask

    task automatic test_backpressure;
        run_tri("backpressure", 0, 0, 3, 0, 0, 3, 5, 1'b1);
        n_vec++;
        if (r_n !== 10 || r_count !== 10 || r_dones !== 1 || r_first !== enc(0, 0)) begin
            n_err++;
            $display("FAIL backpressure totals: pixels=%0d count=%0d dones=%0d first=%0d, required 10 10 1 0",
                     r_n, r_count, r_dones, r_first);
        end
    endtask

    task automatic test_clipping;
        run_tri("clipping", 630, 470, 700, 470, 630, 1000, 0, 1'b0);
        n_vec++;
        if (r_n !== 100 || r_count !== 100 || r_last !== enc(639, 479)) begin
            n_err++;
            $display("FAIL clipping totals: pixels=%0d count=%0d last=%0d, required 100 100 %0d",
                     r_n, r_count, r_last, enc(639, 479));
        end
        run_tri("offscreen", 700, 10, 720, 10, 700, 30, 0, 1'b0);
        n_vec++;
        if (r_n !== 0 || r_count !== 0 || r_done_idx !== 2) begin
            n_err++;
            $display("FAIL offscreen: pixels=%0d count=%0d done_idx=%0d, required 0 0 2", r_n, r_count, r_done_idx);
        end
    endtask

    task automatic test_reset_mid_scan;
        int spurious;
        spurious = 0;
        @(negedge clk);
        p1x = '0; p1y = '0; p2x = 11'd30; p2y = '0; p3x = '0; p3y = 11'd30;
        cmd_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || pix_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midscan_pre: busy=%b pix_valid=%b, required 1/1", busy, pix_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midscan_async: pix_valid=%b busy=%b cmd_ready=%b, required 0 0 1", pix_valid, busy, cmd_ready);
        end
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || pix_valid === 1'b1) spurious++;
        end
        n_vec++;
        if (spurious !== 0) begin
            n_err++;
            $display("FAIL midscan_no_done: got %0d spurious done/pix_valid cycles, required 0", spurious);
        end
        run_tri("after_reset", 0, 0, 1, 0, 0, 1, 0, 1'b0);
        n_vec++;
        if (r_n !== 3 || r_count !== 3 || r_dones !== 1) begin
            n_err++;
            $display("FAIL after_reset totals: pixels=%0d count=%0d dones=%0d, required 3 3 1", r_n, r_count, r_dones);
        end
    endtask

    initial begin
        test_reset();
        test_winding("ccw", 4, 0, 0, 4);
        test_winding("cw", 0, 4, 4, 0);
        test_degenerate("collinear", 0, 0, 2, 2, 4, 4);
        test_degenerate("point", 7, 7, 7, 7, 7, 7);
        test_backpressure();
        test_clipping();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/triangle_raster_scan.md
Name: triangle_raster_scan

Overview:
Triangle rasterizer. It accepts three vertices and sweeps the triangle's bounding box in raster order. It evaluates the same area/edge-function sign test used by our point-in-triangle checker and streams out every covered pixel coordinate over a valid/ready interface. It is the producer side of the point-in-triangle path: it generates the inside points instead of testing one supplied point. It sits between the triangle command source and the pixel writer.

Parameters:
W, 10, coordinate width in bits (unsigned).
MAX_X, 639, largest legal x; the bounding box is clipped to it.
MAX_Y, 479, largest legal y; the bounding box is clipped to it.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  vertex set offered.
cmd_ready  out  1  high only in IDLE.
p1x,p1y,p2x,p2y,p3x,p3y  in  W each  vertices, sampled on cmd accept.
pix_valid  out  1  pix_x/pix_y hold a covered pixel.
pix_ready  in  1  consumer accepts the pixel.
pix_x  out  W  covered pixel x.
pix_y  out  W  covered pixel y.
busy  out  1  high from cmd accept until done.
done  out  1  one-cycle pulse when the triangle is finished.
pix_count  out  2W+1  covered pixels emitted for the last triangle; valid from done until the next accept.

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1; pix_valid=0; busy=0; done=0; pix_x=pix_y=0; pix_count=0.
- Handshakes: cmd accepted when cmd_valid && cmd_ready. A pixel transfers when pix_valid && pix_ready. Once pix_valid is high, pix_x/pix_y are held stable until the transfer.
- State machine:
  - IDLE: on accept, latch vertices, clear pix_count, go to SETUP.
  - SETUP (1 cycle):
    - xmin/xmax/ymin/ymax = min/max of the vertices, with xmax clipped to MAX_X and ymax clipped to MAX_Y.
    - A = p1x*(p2y-p3y)+p2x*(p3y-p1y)+p3x*(p1y-p2y), signed, 2W+3 bits.
    - If A==0 (degenerate or collinear), go to DONE. Otherwise set cx=xmin, cy=ymin and go to SCAN.
  - SCAN: evaluates one candidate (cx,cy) per cycle, and only when the output slot is empty or transferring this cycle. Otherwise the scan stalls with no skipped or duplicated candidates.
    - Edge terms: E1=area(pt,p2,p3), E2=area(p1,pt,p3), E3=area(p1,p2,pt). All are signed 2W+3 bits; sign-extend differences before multiplying.
    - Covered iff every Ei is zero or has the sign of A. Edges and vertices are inclusive, and both windings are supported.
    - A covered candidate loads pix_x/pix_y, sets pix_valid, and increments pix_count.
    - Advance: cx++; at cx==xmax, cx=xmin and cy++; at (xmax,ymax), go to DRAIN.
  - DRAIN: wait until pix_valid==0 (last pixel transferred), then go to DONE.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Latency: accept at cycle T → SETUP at T+1 → first candidate evaluated at T+2 → earliest pix_valid at T+3. Without backpressure the rate is one candidate per cycle, whether covered or not.
- busy=1 in SETUP/SCAN/DRAIN/DONE-entry; cmd_ready=0 throughout. A cmd_valid while busy is ignored and not latched.
- Reset mid-operation: everything is aborted immediately. No done is issued, pix_valid drops, and the partial triangle is discarded.
- Clipping: a vertex beyond MAX_X/MAX_Y produces no pixel beyond MAX_X/MAX_Y. If xmin>MAX_X or ymin>MAX_Y, go SETUP→DONE with count 0.
- No arithmetic wrap: widths are sized so |E| ≤ 2·(2^W)^2 fits.

Decomposition:
- Package tri_pkg: constants W, MAX_X, MAX_Y; AREA_W=2*W+3; state enum {IDLE,SETUP,SCAN,DRAIN,DONE}; a point struct {x,y}.
- One sub-module, tri_area: combinational signed twice-area of three points (AREA_W output). It is instanced 4 times: 1 for SETUP (or shared), 3 for the edges.

Test Plan:
- CCW (0,0),(4,0),(0,4), pix_ready=1 → 15 pixels with x+y≤4, in raster order. First (0,0), last (0,4), pix_count=15, single done pulse.
- CW (0,0),(0,4),(4,0) → identical 15-pixel sequence and count.
- Collinear (0,0),(2,2),(4,4), and separately all vertices (7,7) → no pix_valid, done at accept+2, pix_count=0.
- Triangle (0,0),(3,0),(0,3) with pix_ready low for 5 cycles after the first pix_valid → (0,0) held stable, then 10 pixels total, no duplicates or losses. cmd_valid pulsed mid-scan is ignored.
- Clipping: (630,470),(700,470),(630,1000) with W=11 → no pix_x>639 and no pix_y>479. All emitted pixels satisfy the edge test (reference-model compare).
- rst_n pulsed low mid-SCAN → pix_valid=0 and busy=0 asynchronously, no done. Next triangle (0,0),(1,0),(0,1) → exactly 3 pixels, count 3.
